// File: rtl/spi_pkg.sv
// spi_pkg: command codes, FSM states and widths shared by the SPI master and slave
package spi_pkg;
   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;
   localparam int CNT_W   = 4;
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_SHIFT,
      ST_TRAIL,
      ST_TURN,
      ST_CAPTURE,
      ST_GAP
   } state_t;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: 10-bit PISO for MOSI, 8-bit SIPO for MISO and a 4-bit down-counter
// Ports: clk/rst; i_load + i_frame load the PISO; i_shift shifts it MSB-first (zero fill);
//        i_cap shifts i_miso into the SIPO; i_cnt_load/i_cnt_val preset the counter, which
//        steps down on shift/capture and stops at zero; o_mosi is the PISO MSB;
//        o_rx_next is the byte as it will read once the current i_miso is taken;
//        o_cnt_zero flags the terminal count.
module spi_shift_reg
   import spi_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic [FRAME_W-1:0] i_frame,
   input  logic               i_shift,
   input  logic               i_cap,
   input  logic               i_miso,
   input  logic               i_cnt_load,
   input  logic [CNT_W-1:0]   i_cnt_val,
   output logic               o_mosi,
   output logic [DATA_W-1:0]  o_rx_next,
   output logic               o_cnt_zero
);
   logic [FRAME_W-1:0] r_tx;
   logic [DATA_W-2:0]  r_rx;
   logic [CNT_W-1:0]   r_cnt;
   assign o_mosi     = r_tx[FRAME_W-1];
   assign o_rx_next  = {r_rx, i_miso};
   assign o_cnt_zero = r_cnt == '0;
   // Zero fill leaves MOSI low once all ten bits are out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx  <= '0;
         r_rx  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_load) r_tx <= i_frame;
         else if (i_shift) r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
         if (i_cap) r_rx <= o_rx_next[DATA_W-2:0];
         if (i_cnt_load) r_cnt <= i_cnt_val;
         else if ((i_shift || i_cap) && !o_cnt_zero) r_cnt <= r_cnt - 1'b1;
      end
   end
endmodule

// File: rtl/spi_master.sv
// spi_master: serialises one {cmd, payload} frame per request and captures RD_DATA replies
// Ports: clk/rst (sync, active high); start/cmd/payload request, accepted when ready;
//        done pulses as ss_n returns high; rd_data holds the last RD_DATA byte;
//        seq_err pulses with done for an RD_DATA without a preceding RD_ADDR;
//        ss_n/MOSI/MISO form the serial link to the slave.
module spi_master
   import spi_pkg::*;
#(
   parameter int TURNAROUND = 3,
   parameter int IDLE_GAP   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        cmd,
   input  logic [DATA_W-1:0] payload,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              seq_err,
   output logic              ss_n,
   output logic              MOSI,
   input  logic              MISO
);
   localparam int WAIT_MAX = (TURNAROUND > IDLE_GAP) ? TURNAROUND : IDLE_GAP;
   localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;
   localparam logic [WAIT_W-1:0] TURN_LAST = WAIT_W'(TURNAROUND - 1);
   localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(IDLE_GAP - 1);
   state_t              r_state;
   logic [1:0]          r_cmd;
   logic                r_rd_pend;
   logic [WAIT_W-1:0]   r_wait;
   logic                w_accept;
   logic                w_cnt_load;
   logic                w_cnt_zero;
   logic [CNT_W-1:0]    w_cnt_val;
   logic [DATA_W-1:0]   w_rx_next;
   assign w_accept   = start && ready;
   assign w_cnt_load = (r_state == ST_CMD) || (r_state == ST_TURN && r_wait == '0);
   assign w_cnt_val  = (r_state == ST_CMD) ? CNT_W'(FRAME_W - 1) : CNT_W'(DATA_W - 1);
   spi_shift_reg u_sr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_accept),
      .i_frame    ({cmd, payload}),
      .i_shift    (r_state == ST_SHIFT),
      .i_cap      (r_state == ST_CAPTURE),
      .i_miso     (MISO),
      .i_cnt_load (w_cnt_load),
      .i_cnt_val  (w_cnt_val),
      .o_mosi     (MOSI),
      .o_rx_next  (w_rx_next),
      .o_cnt_zero (w_cnt_zero)
   );
   // The last GAP cycle already shows ready, so it accepts a request exactly like IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cmd     <= '0;
         r_rd_pend <= 1'b0;
         r_wait    <= '0;
         ready     <= 1'b1;
         done      <= 1'b0;
         rd_data   <= '0;
         seq_err   <= 1'b0;
         ss_n      <= 1'b1;
      end else begin
         done    <= 1'b0;
         seq_err <= 1'b0;
         case (r_state)
            ST_IDLE, ST_GAP: begin
               if (w_accept) begin
                  r_state <= ST_CMD;
                  r_cmd   <= cmd;
                  ready   <= 1'b0;
                  ss_n    <= 1'b0;
               end else if (r_state == ST_GAP) begin
                  if (r_wait == '0) r_state <= ST_IDLE;
                  else begin
                     r_wait <= r_wait - 1'b1;
                     ready  <= r_wait == WAIT_W'(1);
                  end
               end
            end
            ST_CMD: r_state <= ST_SHIFT;
            ST_SHIFT: begin
               if (w_cnt_zero) begin
                  r_state <= (r_cmd == CMD_RD_DATA) ? ST_TURN : ST_TRAIL;
                  r_wait  <= TURN_LAST;
               end
            end
            ST_TRAIL: begin
               r_state <= ST_GAP;
               ss_n    <= 1'b1;
               done    <= 1'b1;
               ready   <= IDLE_GAP == 1;
               r_wait  <= GAP_LAST;
               if (r_cmd == CMD_RD_ADDR) r_rd_pend <= 1'b1;
            end
            ST_TURN: begin
               if (r_wait == '0) r_state <= ST_CAPTURE;
               else r_wait <= r_wait - 1'b1;
            end
            ST_CAPTURE: begin
               if (w_cnt_zero) begin
                  r_state   <= ST_GAP;
                  ss_n      <= 1'b1;
                  done      <= 1'b1;
                  ready     <= IDLE_GAP == 1;
                  r_wait    <= GAP_LAST;
                  rd_data   <= w_rx_next;
                  seq_err   <= !r_rd_pend;
                  r_rd_pend <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized self-checking bench for spi_master against a cycle-indexed frame model
module tb_spi_master;
   localparam int T = 3;
   localparam int G = 1;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       MISO = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [7:0] payload = 8'h00;
   logic       ready, done, seq_err, ss_n, MOSI;
   logic [7:0] rd_data;
   int         checks = 0;
   int         failures = 0;
   logic       m_pend = 1'b0;
   logic [7:0] m_rd = 8'h00;
   logic       o_ss [0:63];
   logic       o_mosi [0:63];
   logic       o_done [0:63];
   logic       o_ready [0:63];
   logic       o_err [0:63];
   logic [7:0] o_rd [0:63];

   spi_master #(.TURNAROUND(T), .IDLE_GAP(G)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd(cmd), .payload(payload),
      .ready(ready), .done(done), .rd_data(rd_data), .seq_err(seq_err),
      .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   function automatic int frame_len(input logic [1:0] c);
      return (c == 2'b11) ? 19 + T : 12;
   endfunction

   // Expected {ss_n, MOSI, done, ready, seq_err, rd_data} in cycle k after acceptance
   function automatic logic [12:0] expect_at(input logic [1:0] c, input logic [7:0] p,
                                              input logic [7:0] resp, input int k);
      int L;
      logic [9:0] f;
      logic rd, e_ss, e_mosi, e_done, e_ready, e_err;
      logic [7:0] e_rd;
      L = frame_len(c);
      f = {c, p};
      rd = (c == 2'b11);
      e_ss = !(k >= 1 && k <= L);
      e_mosi = 1'b0;
      if (k == 1) e_mosi = f[9];
      else if (k >= 2 && k <= 11) e_mosi = f[11 - k];
      e_done = (k == L + 1);
      e_ready = (k >= L + G);
      e_err = (k == L + 1) && rd && !m_pend;
      e_rd = (rd && k >= L + 1) ? resp : m_rd;
      return {e_ss, e_mosi, e_done, e_ready, e_err, e_rd};
   endfunction

   task automatic commit(input logic [1:0] c, input logic [7:0] resp);
      if (c == 2'b10) m_pend = 1'b1;
      if (c == 2'b11) begin
         m_rd = resp;
         m_pend = 1'b0;
      end
   endtask

   // Issues one request at a negedge with ready high and records outputs for cycles 1..L+G.
   // The slave model drives resp MSB-first in the capture window, random noise elsewhere.
   task automatic drive_frame(input logic [1:0] c, input logic [7:0] p,
                              input logic [7:0] resp, input bit hold);
      int L;
      L = frame_len(c);
      start = 1'b1;
      cmd = c;
      payload = p;
      for (int k = 1; k <= L + G; k++) begin
         @(negedge clk);
         if (hold) begin
            cmd = 2'($urandom);
            payload = 8'($urandom);
         end
         start = hold && (k < L + G);
         o_ss[k] = ss_n;
         o_mosi[k] = MOSI;
         o_done[k] = done;
         o_ready[k] = ready;
         o_err[k] = seq_err;
         o_rd[k] = rd_data;
         MISO = (c == 2'b11 && k >= 12 + T && k <= 19 + T) ? resp[19 + T - k] : 1'($urandom);
      end
   endtask

   task automatic test_reset();
      int seen;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({ss_n, MOSI, ready, done, seq_err} !== 5'b10100)
         $display("FAIL reset_ctrl got ss_n/MOSI/ready/done/seq_err=%b want 10100",
                  {ss_n, MOSI, ready, done, seq_err});
      if ({ss_n, MOSI, ready, done, seq_err} !== 5'b10100) failures++;
      checks++;
      if (rd_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_rd_data got %h want 00", rd_data);
      end
      start = 1'b1;
      cmd = 2'b00;
      payload = 8'($urandom);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (ss_n !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_active got ss_n=%b want 0", ss_n);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({ss_n, MOSI, ready, done} !== 4'b1010) begin
         failures++;
         $display("FAIL rst_mid_state got ss_n/MOSI/ready/done=%b want 1010", {ss_n, MOSI, ready, done});
      end
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1 || ss_n !== 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL rst_mid_no_done got %0d active cycles want 0", seen);
      end
      m_pend = 1'b0;
      m_rd = 8'h00;
   endtask

   task automatic test_wr_addr();
      logic [12:0] got;
      drive_frame(2'b00, 8'h3C, 8'h00, 1'b0);
      for (int k = 1; k <= 13; k++) got[13 - k] = o_mosi[k];
      checks++;
      if (got !== 13'b0000011110000) begin
         failures++;
         $display("FAIL wr_addr_mosi got %b want 0000011110000", got);
      end
      checks++;
      if ({o_done[12], o_done[13]} !== 2'b01) begin
         failures++;
         $display("FAIL wr_addr_done got done@12,13=%b want 01", {o_done[12], o_done[13]});
      end
      checks++;
      if ({o_ss[1], o_ss[12], o_ss[13], o_ready[1], o_ready[13]} !== 5'b00101) begin
         failures++;
         $display("FAIL wr_addr_ss_ready got %b want 00101",
                  {o_ss[1], o_ss[12], o_ss[13], o_ready[1], o_ready[13]});
      end
      commit(2'b00, 8'h00);
   endtask

   task automatic test_back_to_back();
      logic s12, s13;
      logic [10:0] got;
      drive_frame(2'b00, 8'h3C, 8'h00, 1'b0);
      commit(2'b00, 8'h00);
      s12 = o_ss[12];
      s13 = o_ss[13];
      drive_frame(2'b01, 8'hA5, 8'h00, 1'b0);
      checks++;
      if ({s12, s13, o_ss[1]} !== 3'b010) begin
         failures++;
         $display("FAIL b2b_gap got ss_n around gap=%b want 010", {s12, s13, o_ss[1]});
      end
      for (int k = 1; k <= 11; k++) got[11 - k] = o_mosi[k];
      checks++;
      if (got[10:8] !== 3'b001) begin
         failures++;
         $display("FAIL b2b_first_bits got %b want 001", got[10:8]);
      end
      checks++;
      if (got !== 11'b00110100101) begin
         failures++;
         $display("FAIL b2b_mosi got %b want 00110100101", got);
      end
      checks++;
      if (o_done[13] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_done got %b want 1", o_done[13]);
      end
      commit(2'b01, 8'h00);
   endtask

   task automatic test_rd_pair();
      logic [7:0] old_rd;
      drive_frame(2'b10, 8'h3C, 8'h00, 1'b0);
      commit(2'b10, 8'h00);
      old_rd = m_rd;
      drive_frame(2'b11, 8'h00, 8'hA5, 1'b0);
      checks++;
      if (o_rd[20 + T] !== 8'hA5) begin
         failures++;
         $display("FAIL rd_pair_data got %h want a5", o_rd[20 + T]);
      end
      checks++;
      if ({o_done[19 + T], o_done[20 + T], o_err[20 + T]} !== 3'b010) begin
         failures++;
         $display("FAIL rd_pair_done_err got %b want 010", {o_done[19 + T], o_done[20 + T], o_err[20 + T]});
      end
      checks++;
      if (o_rd[19 + T] !== old_rd) begin
         failures++;
         $display("FAIL rd_pair_hold got %h want %h", o_rd[19 + T], old_rd);
      end
      checks++;
      if ({o_ss[19 + T], o_ss[20 + T]} !== 2'b01) begin
         failures++;
         $display("FAIL rd_pair_ss got %b want 01", {o_ss[19 + T], o_ss[20 + T]});
      end
      commit(2'b11, 8'hA5);
   endtask

   task automatic test_seq_err();
      logic [7:0] r;
      drive_frame(2'b11, 8'h00, 8'h5A, 1'b0);
      checks++;
      if ({o_rd[20 + T], o_done[20 + T], o_err[20 + T], o_err[19 + T]} !== {8'h5A, 3'b110}) begin
         failures++;
         $display("FAIL seq_err_first got rd=%h done=%b err=%b prev_err=%b want rd=5a done=1 err=1 prev_err=0",
                  o_rd[20 + T], o_done[20 + T], o_err[20 + T], o_err[19 + T]);
      end
      commit(2'b11, 8'h5A);
      r = 8'($urandom);
      drive_frame(2'b11, 8'h00, r, 1'b0);
      checks++;
      if ({o_err[1], o_err[20 + T], o_rd[20 + T]} !== {2'b01, r}) begin
         failures++;
         $display("FAIL seq_err_second got err@1=%b err@done=%b rd=%h want 0 1 %h",
                  o_err[1], o_err[20 + T], o_rd[20 + T], r);
      end
      commit(2'b11, r);
      drive_frame(2'b10, 8'($urandom), 8'h00, 1'b0);
      commit(2'b10, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_pend = 1'b0;
      m_rd = 8'h00;
      r = 8'($urandom);
      drive_frame(2'b11, 8'h00, r, 1'b0);
      checks++;
      if ({o_err[20 + T], o_rd[20 + T]} !== {1'b1, r}) begin
         failures++;
         $display("FAIL seq_err_after_reset got err=%b rd=%h want 1 %h", o_err[20 + T], o_rd[20 + T], r);
      end
      commit(2'b11, r);
   endtask

   task automatic test_busy_start();
      logic [7:0] p;
      logic [12:0] exp_v, got;
      int bad, idle_bad;
      p = 8'($urandom);
      bad = -1;
      drive_frame(2'b01, p, 8'h00, 1'b1);
      for (int k = 1; k <= 12 + G; k++) begin
         exp_v = expect_at(2'b01, p, 8'h00, k);
         got = {o_ss[k], o_mosi[k], o_done[k], o_ready[k], o_err[k], o_rd[k]};
         if (got !== exp_v && bad < 0) bad = k;
      end
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL busy_trace cycle=%0d got %h want %h", bad,
                  {o_ss[bad], o_mosi[bad], o_done[bad], o_ready[bad], o_err[bad], o_rd[bad]},
                  expect_at(2'b01, p, 8'h00, bad));
      end
      commit(2'b01, 8'h00);
      idle_bad = 0;
      repeat (6) begin
         @(negedge clk);
         if ({ss_n, ready, done} !== 3'b110) idle_bad++;
      end
      checks++;
      if (idle_bad != 0) begin
         failures++;
         $display("FAIL busy_no_queue got %0d non-idle cycles want 0", idle_bad);
      end
   endtask

   task automatic test_random();
      logic [1:0] c;
      logic [7:0] p, r;
      logic [12:0] exp_v, got;
      int L;
      for (int n = 0; n < 24; n++) begin
         c = 2'($urandom);
         p = (c == 2'b11) ? 8'h00 : 8'($urandom);
         r = 8'($urandom);
         L = frame_len(c);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         drive_frame(c, p, r, 1'b0);
         for (int k = 1; k <= L + G; k++) begin
            exp_v = expect_at(c, p, r, k);
            got = {o_ss[k], o_mosi[k], o_done[k], o_ready[k], o_err[k], o_rd[k]};
            checks++;
            if (got !== exp_v) begin
               failures++;
               $display("FAIL rand_trace frame=%0d cmd=%0d cycle=%0d got %h want %h", n, c, k, got, exp_v);
            end
         end
         commit(c, r);
      end
   endtask

   initial begin
      test_reset();
      test_wr_addr();
      test_back_to_back();
      test_rd_pair();
      test_seq_err();
      test_busy_start();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
